// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: ramps a PWM duty cycle toward a handshaked target in fixed steps.
//   Optional feature macro: PWM_CTRL_SOFTSTOP_EN (stop ramps duty down to 0 before idling).
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     start, stop           single-cycle run/stop requests (stop wins)
//     tgt_valid/tgt_ready   target handshake; tgt_duty, tgt_invert carry the target
//     duty_cycle, invert,   registered drives for the PWM core
//     enable
//     busy, at_target       registered status
module pwm_ramp_ctrl #(
    parameter int RAMP_STEP        = 16,
    parameter int PERIODS_PER_STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    input  logic [7:0] tgt_duty,
    input  logic       tgt_invert,
    output logic [7:0] duty_cycle,
    output logic       invert,
    output logic       enable,
    output logic       busy,
    output logic       at_target
);
    typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOP} state_t;

    localparam logic [7:0] STEP   = 8'(RAMP_STEP);
    localparam logic [7:0] PPS_M1 = 8'(PERIODS_PER_STEP - 1);

    state_t     state;
    logic [7:0] target;
    logic [7:0] cnt;
    logic [7:0] scnt;
    logic       inv_pend;
    logic       inv_pv;
    logic       xfer;
    logic       boundary;
    logic       step_ev;
    logic       up;
    logic [7:0] gap;
    logic [7:0] mv;
    logic [7:0] stepped;
    logic [7:0] t_eff;

    assign tgt_ready = state != STOP;
    assign xfer      = tgt_valid && tgt_ready;
    assign boundary  = enable && cnt == 8'hff;
    assign step_ev   = boundary && scnt == PPS_M1;
    // Step size is clipped to the remaining distance, so no overshoot or wrap.
    assign up        = target > duty_cycle;
    assign gap       = up ? target - duty_cycle : duty_cycle - target;
    assign mv        = gap < STEP ? gap : STEP;
    assign stepped   = up ? duty_cycle + mv : duty_cycle - mv;
    // Target as it will stand after this cycle's transfer, if any.
    assign t_eff     = xfer ? tgt_duty : target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            duty_cycle <= 8'd0;
            invert     <= 1'b0;
            enable     <= 1'b0;
            busy       <= 1'b0;
            at_target  <= 1'b0;
            target     <= 8'd0;
            cnt        <= 8'd0;
            scnt       <= 8'd0;
            inv_pend   <= 1'b0;
            inv_pv     <= 1'b0;
        end else begin
            cnt <= enable ? cnt + 8'd1 : 8'd0;
            if (boundary)
                scnt <= step_ev ? 8'd0 : scnt + 8'd1;
            // A polarity change while running waits for a period boundary to avoid a glitch.
            if (inv_pv && (boundary || !enable)) begin
                invert <= inv_pend;
                inv_pv <= 1'b0;
            end
            if (xfer && !stop) begin
                target <= tgt_duty;
                if (enable) begin
                    inv_pend <= tgt_invert;
                    inv_pv   <= 1'b1;
                end else begin
                    invert <= tgt_invert;
                end
            end
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        enable     <= 1'b1;
                        duty_cycle <= 8'd0;
                        cnt        <= 8'd0;
                        scnt       <= 8'd0;
                        busy       <= 1'b1;
                        state      <= t_eff == 8'd0 ? HOLD : RAMP;
                        at_target  <= t_eff == 8'd0;
                    end
                end
                RAMP, HOLD: begin
                    if (stop) begin
`ifdef PWM_CTRL_SOFTSTOP_EN
                        state     <= STOP;
                        target    <= 8'd0;
                        at_target <= 1'b0;
`else
                        state      <= IDLE;
                        enable     <= 1'b0;
                        duty_cycle <= 8'd0;
                        cnt        <= 8'd0;
                        scnt       <= 8'd0;
                        busy       <= 1'b0;
                        at_target  <= 1'b0;
`endif
                    end else if (state == RAMP) begin
                        if (step_ev)
                            duty_cycle <= stepped;
                        if ((step_ev ? stepped : duty_cycle) == t_eff) begin
                            state     <= HOLD;
                            at_target <= 1'b1;
                        end
                    end else if (xfer && tgt_duty != duty_cycle) begin
                        state     <= RAMP;
                        scnt      <= 8'd0;
                        at_target <= 1'b0;
                    end
                end
                STOP: begin
                    if (duty_cycle == 8'd0) begin
                        state  <= IDLE;
                        enable <= 1'b0;
                        cnt    <= 8'd0;
                        busy   <= 1'b0;
                    end else if (step_ev) begin
                        duty_cycle <= stepped;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter RAMP_STEP, default 16: duty increment/decrement applied per step event (1..255).
REQ-002 SHALL have parameter PERIODS_PER_STEP, default 1: PWM periods between step events (1..255).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin driving the PWM.
REQ-006 SHALL have port stop  input  1  single-cycle request to stop driving the PWM.
REQ-007 SHALL have port tgt_valid  input  1  new target offered.
REQ-008 SHALL have port tgt_ready  output  1  controller can accept a target.
REQ-009 SHALL have port tgt_duty  input  8  requested duty, 0..255.
REQ-010 SHALL have port tgt_invert  input  1  requested output polarity.
REQ-011 SHALL have port duty_cycle  output  8  drives pwm duty_cycle.
REQ-012 SHALL have port invert  output  1  drives pwm invert.
REQ-013 SHALL have port enable  output  1  drives pwm enable.
REQ-014 SHALL have port busy  output  1  high when state is not IDLE.
REQ-015 SHALL have port at_target  output  1  high in HOLD with duty_cycle equal to target.

Function
REQ-016 SHALL implement states IDLE, RAMP, HOLD, STOP; all outputs registered except tgt_ready.
REQ-017 SHALL run an 8-bit period counter, +1 per cycle while enable=1, wrap 255->0, held at 0 while enable=0; boundary = count 255.
REQ-018 SHALL generate a step event on every PERIODS_PER_STEP-th boundary; the step counter clears on entry to RAMP.
REQ-019 SHALL drive tgt_ready = 1 in every state except STOP; a transfer occurs when tgt_valid and tgt_ready are both high, and the target register updates next cycle.
REQ-020 SHALL apply an accepted tgt_invert to invert at the next boundary when enable=1, or on the next cycle when enable=0.
REQ-021 On start in IDLE, SHALL set enable=1 and duty_cycle=0 next cycle and go to RAMP, or to HOLD if target=0; start outside IDLE is ignored.
REQ-022 On a step event in RAMP or STOP, SHALL move duty_cycle toward the target by min(RAMP_STEP, |target-duty|), saturating with no overshoot or 8-bit wrap.
REQ-023 SHALL go RAMP->HOLD on the cycle duty_cycle becomes equal to target.
REQ-024 SHALL go HOLD->RAMP on the cycle after a target differing from duty_cycle is accepted.
REQ-025 SHALL give stop priority over start and over a same-cycle target transfer; the transfer handshakes but the target is discarded.
REQ-026 SHALL treat stop in IDLE as a no-op.

Reset
REQ-027 While rst=1, SHALL set state IDLE, duty_cycle=0, invert=0, enable=0, busy=0, at_target=0, target=0, and both counters 0; rst overrides all inputs, mid-ramp included.

Configuration
REQ-028 With PWM_CTRL_SOFTSTOP_EN defined, stop in RAMP/HOLD SHALL enter STOP, force the target to 0 and ramp down per REQ-022; when duty_cycle reaches 0, enable=0 and IDLE follow next cycle.
REQ-029 Without PWM_CTRL_SOFTSTOP_EN, stop in RAMP/HOLD SHALL set enable=0 and duty_cycle=0 and return to IDLE next cycle; state STOP is unreachable.

Verification
REQ-030 Defaults, accept tgt_duty=64, pulse start -> duty_cycle 0,16,32,48,64 at boundaries 256 cycles apart; at_target=1 after 4 periods.
REQ-031 In HOLD at 64, accept tgt_duty=60 -> duty_cycle 60 at the next boundary, no undershoot; HOLD re-entered.
REQ-032 Accept tgt_duty=255 at 240 -> next step 255, no wrap to 0.
REQ-033 With SOFTSTOP_EN at duty 48, stop -> 32,16,0 over 3 periods, then enable=0, busy=0; tgt_ready=0 throughout STOP.
REQ-034 Without SOFTSTOP_EN, stop mid-ramp -> next cycle enable=0, duty_cycle=0, IDLE; start+stop same cycle in IDLE -> stays IDLE.
REQ-035 Assert rst for 1 cycle mid-ramp at duty 32 -> all outputs 0 next cycle; the later start ramps from 0 toward target 0 and goes straight to HOLD.
